call_stack_ctrl: RTL

//  Initiator side of the register-file stack interface. Turns CALL/RET requests from the control unit into

---
 rtl/call_stack_ctrl_pkg.sv | 15 +
 rtl/call_stack_ctrl_if.sv | 22 ++
 rtl/call_stack_ctrl_lifo.sv | 31 +++
 rtl/call_stack_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/call_stack_ctrl_pkg.sv
// Shared types for the call/return stack controller.
// The FSM state encoding and the empty-stack pointer value live here.
package cs_pkg;

   typedef enum logic [2:0] {
      CS_IDLE      = 3'd0,
      CS_CALL_INC  = 3'd1,
      CS_CALL_PUSH = 3'd2,
      CS_RET_RD    = 3'd3,
      CS_RET_POP   = 3'd4
   } cs_state_t;

   localparam int CS_PTR_EMPTY = 0;

endpackage

// File: rtl/call_stack_ctrl_if.sv
// Request/response bundle between the control unit (master) and call_stack_ctrl (slave).
interface call_stack_ctrl_if #(parameter int PC_WIDTH = 6);

   logic                cs_call;
   logic                cs_ret;
   logic [PC_WIDTH-1:0] cs_call_target;
   logic [PC_WIDTH-1:0] cs_pc_next;
   logic                cs_pc_load;
   logic [PC_WIDTH-1:0] cs_pc_value;
   logic                cs_busy;

   modport master (
      output cs_call, cs_ret, cs_call_target, cs_pc_next,
      input  cs_pc_load, cs_pc_value, cs_busy
   );

   modport slave (
      input  cs_call, cs_ret, cs_call_target, cs_pc_next,
      output cs_pc_load, cs_pc_value, cs_busy
   );

endinterface

// File: rtl/call_stack_ctrl_lifo.sv
// Return-address store: frame f (1..DEPTH) lives in slot f-1; frame 0 is the empty
// stack and is never written. One write port, combinational read.
module ret_addr_lifo #(
   parameter int PC_WIDTH = 6,
   parameter int DEPTH    = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic [PC_WIDTH-1:0] waddr,
   input  logic [PC_WIDTH-1:0] wdata,
   input  logic [PC_WIDTH-1:0] raddr,
   output logic [PC_WIDTH-1:0] rdata
);

   logic [PC_WIDTH-1:0] mem [DEPTH];

   // NOTE: storage arrays carry no reset; only control state needs a known value.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (we && waddr == PC_WIDTH'(i + 1)) mem[i] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr == PC_WIDTH'(i + 1)) rdata = mem[i];
      end
   end

endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/RET sequencer: issues push/pop strobes and a frame pointer to reg_f,
// and reloads the PC from the call target or the stored return address.
module call_stack_ctrl
   import cs_pkg::*;
#(
   parameter int PC_WIDTH = 6,
   parameter int DEPTH    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   call_stack_ctrl_if.slave    cs,
   input  logic                cs_err_clr,
   output logic                rf_stack_push,
   output logic                rf_stack_pop,
   output logic [PC_WIDTH-1:0] rf_stack_pointer,
   output logic                cs_overflow,
   output logic                cs_underflow
);

   localparam logic [PC_WIDTH-1:0] PTR_FULL  = PC_WIDTH'(DEPTH);
   localparam logic [PC_WIDTH-1:0] PTR_EMPTY = PC_WIDTH'(CS_PTR_EMPTY);

   cs_state_t           state_q, state_d;
   logic [PC_WIDTH-1:0] ptr_q, ptr_d;
   logic [PC_WIDTH-1:0] target_q, target_d;
   logic [PC_WIDTH-1:0] ret_addr_q, ret_addr_d;
   logic [PC_WIDTH-1:0] value_q, value_d;
   logic                push_q, push_d, pop_q, pop_d, load_q, load_d, busy_q, busy_d;
   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic                lifo_we;
   logic [PC_WIDTH-1:0] lifo_rdata;

   ret_addr_lifo #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_lifo (
      .clk   (clk),
      .we    (lifo_we),
      .waddr (ptr_q),
      .wdata (ret_addr_q),
      .raddr (ptr_q),
      .rdata (lifo_rdata)
   );

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      target_d   = target_q;
      ret_addr_d = ret_addr_q;
      value_d    = value_q;
      push_d     = 1'b0;
      pop_d      = 1'b0;
      load_d     = 1'b0;
      lifo_we    = 1'b0;
      ovf_d      = cs_err_clr ? 1'b0 : ovf_q;
      unf_d      = cs_err_clr ? 1'b0 : unf_q;
      unique case (state_q)
         CS_IDLE: begin
            // A simultaneous return is dropped silently when a call is present.
            if (cs.cs_call) begin
               if (ptr_q < PTR_FULL) begin
                  state_d    = CS_CALL_INC;
                  target_d   = cs.cs_call_target;
                  ret_addr_d = cs.cs_pc_next;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (cs.cs_ret) begin
               if (ptr_q != PTR_EMPTY) state_d = CS_RET_RD;
               else                    unf_d   = 1'b1;
            end
         end
         CS_CALL_INC: begin
            state_d = CS_CALL_PUSH;
            ptr_d   = ptr_q + 1'b1;
            push_d  = 1'b1;
            load_d  = 1'b1;
            value_d = target_q;
         end
         CS_CALL_PUSH: begin
            state_d = CS_IDLE;
            lifo_we = 1'b1;
         end
         CS_RET_RD: begin
            state_d = CS_RET_POP;
            pop_d   = 1'b1;
            load_d  = 1'b1;
            value_d = lifo_rdata;
         end
         CS_RET_POP: begin
            state_d = CS_IDLE;
            ptr_d   = ptr_q - 1'b1;
         end
         default: state_d = CS_IDLE;
      endcase
      busy_d = (state_d != CS_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CS_IDLE;
         ptr_q      <= PTR_EMPTY;
         target_q   <= '0;
         ret_addr_q <= '0;
         value_q    <= '0;
         push_q     <= 1'b0;
         pop_q      <= 1'b0;
         load_q     <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         target_q   <= target_d;
         ret_addr_q <= ret_addr_d;
         value_q    <= value_d;
         push_q     <= push_d;
         pop_q      <= pop_d;
         load_q     <= load_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign rf_stack_push    = push_q;
   assign rf_stack_pop     = pop_q;
   assign rf_stack_pointer = ptr_q;
   assign cs_overflow      = ovf_q;
   assign cs_underflow     = unf_q;
   assign cs.cs_pc_load    = load_q;
   assign cs.cs_pc_value   = value_q;
   assign cs.cs_busy       = busy_q;

endmodule
